// File: rtl/cpu_wb_arbiter.sv
// Register-bank writeback arbiter: the multiplier has fixed priority, then the
// buffered pipeline entries in order, then a fresh pipeline result.
module cpu_wb_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RID_W      = 5,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mul_wb_valid,
  input  logic [RID_W-1:0]         mul_rd_id,
  input  logic [DATA_W-1:0]        mul_result,
  input  logic                     pipe_wb_valid,
  input  logic [RID_W-1:0]         pipe_rd_id,
  input  logic [DATA_W-1:0]        pipe_data,
  output logic                     pipe_stall,
  output logic                     rf_we,
  output logic [RID_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic [(1<<RID_W)-1:0]    pend_mask,
  output logic                     waw_err
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  // Shift-register buffer: entry 0 is the head, entries below count_q are valid.
  logic [RID_W-1:0]  rid_q  [FIFO_DEPTH];
  logic [DATA_W-1:0] data_q [FIFO_DEPTH];
  logic [RID_W-1:0]  rid_n  [FIFO_DEPTH];
  logic [DATA_W-1:0] data_n [FIFO_DEPTH];
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_n;
  logic [CNT_W-1:0]  wr_idx;

  logic              fifo_empty;
  logic              accept;
  logic              direct;
  logic              enq;
  logic              deq;
  logic              waw_hit;
  logic              sel_we;
  logic [RID_W-1:0]  sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Stall depends only on the registered occupancy.
  assign pipe_stall = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign accept     = pipe_wb_valid && !pipe_stall;
  assign direct     = accept && !mul_wb_valid && fifo_empty;
  assign enq        = accept && !direct;
  assign deq        = !mul_wb_valid && !fifo_empty;
  assign wr_idx     = count_q - CNT_W'(deq);
  assign count_n    = count_q + CNT_W'(enq) - CNT_W'(deq);

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = rf_waddr;
    sel_data = rf_wdata;
    if (mul_wb_valid) begin
      sel_we   = 1'b1;
      sel_addr = mul_rd_id;
      sel_data = mul_result;
    end else if (!fifo_empty) begin
      sel_we   = 1'b1;
      sel_addr = rid_q[0];
      sel_data = data_q[0];
    end else if (direct) begin
      sel_we   = 1'b1;
      sel_addr = pipe_rd_id;
      sel_data = pipe_data;
    end
  end

  always_comb begin
    rid_n  = rid_q;
    data_n = data_q;
    if (deq) begin
      for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
        rid_n[i]  = rid_q[i+1];
        data_n[i] = data_q[i+1];
      end
    end
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (enq && (CNT_W'(i) == wr_idx)) begin
        rid_n[i]  = pipe_rd_id;
        data_n[i] = pipe_data;
      end
    end
  end

  // Collision: mul targets a buffered register or the pipe result accepted alongside it.
  always_comb begin
    waw_hit = accept && (mul_rd_id == pipe_rd_id);
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if ((CNT_W'(i) < count_q) && (rid_q[i] == mul_rd_id)) waw_hit = 1'b1;
    end
    waw_hit = waw_hit && mul_wb_valid;
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (CNT_W'(i) < count_q) pend_mask[rid_q[i]] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q  <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      waw_err  <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        rid_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      count_q  <= count_n;
      rf_we    <= sel_we;
      rf_waddr <= sel_addr;
      rf_wdata <= sel_data;
      if (waw_hit) waw_err <= 1'b1;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        rid_q[i]  <= rid_n[i];
        data_q[i] <= data_n[i];
      end
    end
  end

endmodule

// File: tb/tb_cpu_wb_arbiter.sv
// Directed bench for cpu_wb_arbiter with hand-computed writeback sequences.
module tb_cpu_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        mul_wb_valid;
  logic [4:0]  mul_rd_id;
  logic [31:0] mul_result;
  logic        pipe_wb_valid;
  logic [4:0]  pipe_rd_id;
  logic [31:0] pipe_data;
  logic        pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pend_mask;
  logic        waw_err;

  int n_cmp = 0;
  int n_bad = 0;

  cpu_wb_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .mul_wb_valid  (mul_wb_valid),
    .mul_rd_id     (mul_rd_id),
    .mul_result    (mul_result),
    .pipe_wb_valid (pipe_wb_valid),
    .pipe_rd_id    (pipe_rd_id),
    .pipe_data     (pipe_data),
    .pipe_stall    (pipe_stall),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .pend_mask     (pend_mask),
    .waw_err       (waw_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic pv, input logic [4:0] prd, input logic [31:0] pd);
    mul_wb_valid  = mv;
    mul_rd_id     = mrd;
    mul_result    = md;
    pipe_wb_valid = pv;
    pipe_rd_id    = prd;
    pipe_data     = pd;
  endtask

  task automatic check_write(input string tag, input logic [4:0] addr, input logic [31:0] data);
    check({tag, "_we"}, 64'(rf_we), 64'd1);
    check({tag, "_addr"}, 64'(rf_waddr), 64'(addr));
    check({tag, "_data"}, 64'(rf_wdata), 64'(data));
  endtask

  initial begin
    logic [4:0]  exp_addr [7];
    logic [31:0] exp_data [7];
    logic        exp_stall [8];
    int p;

    // Reset with a live pipe request that must be ignored.
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44);
    step();
    step();
    check("rst_we", 64'(rf_we), 64'd0);
    check("rst_addr", 64'(rf_waddr), 64'd0);
    check("rst_data", 64'(rf_wdata), 64'd0);
    check("rst_waw", 64'(waw_err), 64'd0);
    check("rst_pend", 64'(pend_mask), 64'd0);
    check("rst_stall", 64'(pipe_stall), 64'd0);
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    check("rst_ignored_we", 64'(rf_we), 64'd0);

    // Pipe-only direct write.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h11);
    step();
    check_write("pipe_only", 5'd3, 32'h11);
    check("pipe_only_pend", 64'(pend_mask), 64'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Same-cycle mul and pipe: mul first, pipe buffered for one cycle.
    drive(1'b1, 5'd5, 32'hAA, 1'b1, 5'd6, 32'hBB);
    step();
    check_write("coll_mul", 5'd5, 32'hAA);
    check("coll_pend6", 64'(pend_mask), 64'h40);
    check("coll_waw", 64'(waw_err), 64'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    check_write("coll_pipe", 5'd6, 32'hBB);
    check("coll_pend_clr", 64'(pend_mask), 64'd0);
    step();
    check("idle_we", 64'(rf_we), 64'd0);
    check("idle_addr_hold", 64'(rf_waddr), 64'd6);
    check("idle_data_hold", 64'(rf_wdata), 64'hBB);

    // Full buffer: four mul cycles starve the pipe, which fills the buffer and stalls.
    exp_addr = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd1, 5'd2, 5'd3};
    exp_data = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h201, 32'h202, 32'h203};
    exp_stall = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    p = 0;
    for (int c = 0; c < 8; c++) begin
      logic acc;
      drive(c < 4, 5'(10 + c), 32'hA0 + 32'(c),
            p < 3, 5'(p + 1), 32'h201 + 32'(p));
      acc = pipe_wb_valid && !pipe_stall;
      step();
      if (acc) p++;
      if (c < 7) check_write($sformatf("full_c%0d", c), exp_addr[c], exp_data[c]);
      else       check("full_end_we", 64'(rf_we), 64'd0);
      check($sformatf("full_stall_c%0d", c), 64'(pipe_stall), 64'(exp_stall[c]));
    end
    check("full_accepts", 64'(p), 64'd3);
    check("full_waw", 64'(waw_err), 64'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // WAW: buffer holds rd7, then mul writes rd7.
    drive(1'b1, 5'd20, 32'h20, 1'b1, 5'd7, 32'h70);
    step();
    check_write("waw_m20", 5'd20, 32'h20);
    check("waw_pend7", 64'(pend_mask), 64'h80);
    check("waw_pre", 64'(waw_err), 64'd0);
    drive(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0);
    step();
    check_write("waw_mul7", 5'd7, 32'h77);
    check("waw_set", 64'(waw_err), 64'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    check_write("waw_buf7", 5'd7, 32'h70);
    step();
    check("waw_sticky", 64'(waw_err), 64'd1);

    // Reset with two buffered entries: they must never be written.
    drive(1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h99);
    step();
    drive(1'b1, 5'd10, 32'hCC, 1'b1, 5'd11, 32'hBB1);
    step();
    check("mid_stall_full", 64'(pipe_stall), 64'd1);
    check("mid_pend", 64'(pend_mask), 64'h0A00);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_we", 64'(rf_we), 64'd0);
    check("mid_addr", 64'(rf_waddr), 64'd0);
    check("mid_data", 64'(rf_wdata), 64'd0);
    check("mid_waw", 64'(waw_err), 64'd0);
    check("mid_pend0", 64'(pend_mask), 64'd0);
    check("mid_stall", 64'(pipe_stall), 64'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("mid_post_we_c%0d", c), 64'(rf_we), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
